pea_maxpool2x2: RTL and testbench

- Downstream stage of the PE-array filter bank. Consumes the quantized per-lane conv result stream (`PEA_num` lanes × 8 bit, raster order) and performs 2×2, stride-2 max pooling on every lane in parallel.
- Emits one pooled word per 2×2 window to the output writer.
- Frame geometry is set per frame by `col`/`row`, the same values that drive the filter bank.

---
 rtl/pea_maxpool2x2_pkg.sv | 13 +
 rtl/pea_maxpool2x2_pool_line_buf.sv | 26 ++
 rtl/pea_maxpool2x2.sv | 130 +++++++++++++
 tb/tb_pea_maxpool2x2.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pea_maxpool2x2_pkg.sv
// Shared definitions for the 2x2 stride-2 max-pool stage: lane geometry and FSM encoding.
package pea_maxpool2x2_pkg;

  localparam int unsigned PEA_NUM_DEF = 4;
  localparam int unsigned LANE_DW     = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/pea_maxpool2x2_pool_line_buf.sv
// Single-port line buffer with synchronous read; one write or one read per cycle.
module pea_maxpool2x2_pool_line_buf #(
  parameter int unsigned Depth = 128,
  parameter int unsigned Width = 32,
  localparam int unsigned AW   = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  // rdata only changes on a read so it stays valid across input gaps
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/pea_maxpool2x2.sv
// 2x2 stride-2 signed max pooling over PEA_NUM parallel lanes of a raster pixel stream.
// Define POOL_RELU_EN to clamp negative pooled lanes to zero.
module pea_maxpool2x2
  import pea_maxpool2x2_pkg::*;
#(
  parameter int unsigned PEA_NUM = PEA_NUM_DEF,
  parameter int unsigned MAX_COL = 256,
  parameter int unsigned DW      = LANE_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8:0]            col,
  input  logic [8:0]            row,
  input  logic [PEA_NUM*DW-1:0] sum_in,
  input  logic                  sum_valid,
  output logic [PEA_NUM*DW-1:0] pool_out,
  output logic                  pool_valid,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned Depth = MAX_COL / 2;
  localparam int unsigned AW    = $clog2(Depth);
  localparam int unsigned W     = PEA_NUM * DW;

  state_e       state_q;
  logic [8:0]   col_q, row_q, c_q, r_q;
  logic [W-1:0] h_q, lb_rdata, hmax, pooled;
  logic         beat, c_last, r_last, in_win, lb_we, lb_re;

  assign beat   = (state_q == StRun) && sum_valid;
  assign c_last = (c_q == col_q - 9'd1);
  assign r_last = (r_q == row_q - 9'd1);
  // Odd trailing column/row fall outside every window
  assign in_win = (c_q < {col_q[8:1], 1'b0}) && (r_q < {row_q[8:1], 1'b0});
  assign lb_we  = beat && in_win && !r_q[0] && c_q[0];
  assign lb_re  = beat && in_win && r_q[0] && !c_q[0];

  pea_maxpool2x2_pool_line_buf #(
    .Depth (Depth),
    .Width (W)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .re    (lb_re),
    .addr  (c_q[AW:1]),
    .wdata (hmax),
    .rdata (lb_rdata)
  );

  for (genvar i = 0; i < PEA_NUM; i++) begin : g_lane
    logic signed [DW-1:0] px, hv, lb, m_h, m_w;
    assign px  = sum_in[(i+1)*DW-1 -: DW];
    assign hv  = h_q[(i+1)*DW-1 -: DW];
    assign lb  = lb_rdata[(i+1)*DW-1 -: DW];
    assign m_h = (px > hv) ? px : hv;
    assign m_w = (lb > m_h) ? lb : m_h;
    assign hmax[(i+1)*DW-1 -: DW] = m_h;
`ifdef POOL_RELU_EN
    assign pooled[(i+1)*DW-1 -: DW] = m_w[DW-1] ? '0 : m_w;
`else
    assign pooled[(i+1)*DW-1 -: DW] = m_w;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      c_q        <= '0;
      r_q        <= '0;
      h_q        <= '0;
      pool_out   <= '0;
      pool_valid <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pool_valid <= 1'b0;
      frame_done <= 1'b0;
      if (beat && !c_q[0]) begin
        h_q <= sum_in;
      end
      if (beat && in_win && r_q[0] && c_q[0]) begin
        pool_out   <= pooled;
        pool_valid <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            col_q <= col;
            row_q <= row;
            c_q   <= '0;
            r_q   <= '0;
            busy  <= 1'b1;
            if (col < 9'd2 || row < 9'd2) begin
              state_q    <= StDone;
              frame_done <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (sum_valid) begin
            if (c_last) begin
              c_q <= '0;
              if (r_last) begin
                r_q        <= '0;
                state_q    <= StDone;
                frame_done <= 1'b1;
              end else begin
                r_q <= r_q + 9'd1;
              end
            end else begin
              c_q <= c_q + 9'd1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pea_maxpool2x2.sv
// Directed bench for pea_maxpool2x2 with hand-computed pooled values and timing.
module tb_pea_maxpool2x2;

  localparam int P  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [8:0]    col = '0;
  logic [8:0]    row = '0;
  logic [P*DW-1:0] sum_in = '0;
  logic          sum_valid = 1'b0;
  logic [P*DW-1:0] pool_out;
  logic          pool_valid, busy, frame_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;
  logic [31:0] q_out[$];
  int q_cyc[$];
  int fd_cyc[$];
  int exp_cyc[$];

  pea_maxpool2x2 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .col        (col),
    .row        (row),
    .sum_in     (sum_in),
    .sum_valid  (sum_valid),
    .pool_out   (pool_out),
    .pool_valid (pool_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pool_valid) begin
      q_out.push_back(pool_out);
      q_cyc.push_back(cyc);
    end
    if (frame_done) fd_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int lane(input logic [31:0] w, input int i);
    logic [7:0] b;
    b = w[i*8 +: 8];
    return int'($signed(b));
  endfunction

  function automatic logic [31:0] word4(input int a, input int b);
    logic [7:0] a8, b8;
    a8 = a[7:0];
    b8 = b[7:0];
    return {b8, b8, b8, a8};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q;
    q_out.delete();
    q_cyc.delete();
    fd_cyc.delete();
    exp_cyc.delete();
  endtask

  task automatic start_frame(input int w, input int h);
    col   = w[8:0];
    row   = h[8:0];
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed_word(input logic [31:0] wd);
    sum_in    = wd;
    sum_valid = 1'b1;
    step();
    sum_valid = 1'b0;
    last_acc  = cyc;
  endtask

  // Lane0 = r*w+c, other lanes = -(r*w+c); optional gap after each beat,
  // optional abort after nmax pixels, optional stray start before pixel mid_start.
  task automatic run(input int w, input int h, input bit gaps, input int nmax, input int mid_start);
    int n = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (n != nmax) begin
          if (n == mid_start) begin
            col = 9'd2;
            row = 9'd2;
            start = 1'b1;
            step();
            start = 1'b0;
          end
          feed_word(word4(r * w + c, -(r * w + c)));
          n++;
          if (r % 2 == 1 && c % 2 == 1 && c < 2 * (w / 2) && r < 2 * (h / 2))
            exp_cyc.push_back(cyc);
          if (gaps) step();
        end
      end
    end
    step();
    step();
  endtask

  task automatic check_frame(input string tag, input int e0[$], input int eo[$]);
    check({tag, "_count"}, q_out.size(), e0.size());
    for (int i = 0; i < e0.size(); i++) begin
      int g0, g1, g3, gc;
      g0 = (i < q_out.size()) ? lane(q_out[i], 0) : 999;
      g1 = (i < q_out.size()) ? lane(q_out[i], 1) : 999;
      g3 = (i < q_out.size()) ? lane(q_out[i], 3) : 999;
      gc = (i < q_cyc.size()) ? q_cyc[i] : -1;
      check($sformatf("%s_l0_%0d", tag, i), g0, relu(e0[i]));
      check($sformatf("%s_l1_%0d", tag, i), g1, relu(eo[i]));
      check($sformatf("%s_l3_%0d", tag, i), g3, relu(eo[i]));
      check($sformatf("%s_cyc_%0d", tag, i), gc, (i < exp_cyc.size()) ? exp_cyc[i] : -2);
    end
    check({tag, "_fd_n"}, fd_cyc.size(), 1);
    check({tag, "_fd_cyc"}, (fd_cyc.size() > 0) ? fd_cyc[0] : -1, last_acc);
    check({tag, "_busy_end"}, int'(busy), 0);
  endtask

  initial begin
    step();
    step();
    check("rst_pool_out", int'(pool_out), 0);
    check("rst_pool_valid", int'(pool_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    rst = 1'b0;
    step();

    // 4x4 continuous
    clear_q();
    start_frame(4, 4);
    check("t1_busy", int'(busy), 1);
    run(4, 4, 1'b0, -1, -1);
    check_frame("t1", '{5, 7, 13, 15}, '{0, -2, -8, -10});

    // 5x3 odd width and height
    clear_q();
    start_frame(5, 3);
    run(5, 3, 1'b0, -1, -1);
    check_frame("t2", '{6, 8}, '{0, -2});

    // 4x2 with gaps between beats
    clear_q();
    start_frame(4, 2);
    run(4, 2, 1'b1, -1, -1);
    check_frame("t3", '{5, 7}, '{0, -2});

    // signed extremes
    clear_q();
    start_frame(2, 2);
    feed_word({4{8'h80}});
    feed_word({4{8'h7f}});
    feed_word({4{8'hff}});
    feed_word({4{8'h00}});
    step();
    start_frame(2, 2);
    for (int k = 0; k < 4; k++) feed_word({4{8'h80}});
    step();
    check("t4_count", q_out.size(), 2);
    check("t4_mix_l0", (q_out.size() > 0) ? lane(q_out[0], 0) : 999, 127);
    check("t4_mix_l2", (q_out.size() > 0) ? lane(q_out[0], 2) : 999, 127);
    check("t4_min_l0", (q_out.size() > 1) ? lane(q_out[1], 0) : 999, relu(-128));
    check("t4_min_l3", (q_out.size() > 1) ? lane(q_out[1], 3) : 999, relu(-128));

    // abort an 8x8 frame after 6 pixels
    clear_q();
    start_frame(8, 8);
    run(8, 8, 1'b0, 6, -1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    check("t5_abort_pv", q_out.size(), 0);
    check("t5_abort_fd", fd_cyc.size(), 0);
    check("t5_abort_busy", int'(busy), 0);

    // fresh 4x4 frame with a stray start mid-run
    clear_q();
    start_frame(4, 4);
    run(4, 4, 1'b0, -1, 5);
    check_frame("t5", '{5, 7, 13, 15}, '{0, -2, -8, -10});

    // degenerate width
    clear_q();
    start_frame(1, 4);
    check("t6_fd_now", int'(frame_done), 1);
    check("t6_busy_now", int'(busy), 1);
    step();
    check("t6_fd_after", int'(frame_done), 0);
    check("t6_busy_after", int'(busy), 0);
    step();
    check("t6_no_out", q_out.size(), 0);
    check("t6_fd_n", fd_cyc.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
